// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmit states, frame geometry, command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_STOP_IDX   = 10;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  // Host-to-device frame, index 0 goes out first: start 0, data LSB first,
  // odd parity, stop 1.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus a falling-edge
// detector on the synchronized clock. Shared with the receive path.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2c,
  input  logic ps2d,
  output logic ps2c_s,
  output logic ps2d_s,
  output logic fe
);

  logic [1:0] c_sync;
  logic [1:0] d_sync;
  logic       c_prev;

  // Resynchronize both pads; flops start high (idle bus) so no edge fires out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_sync <= '1;
      d_sync <= '1;
      c_prev <= 1'b1;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
      c_prev <= c_sync[1];
    end
  end

  assign ps2c_s = c_sync[1];
  assign ps2d_s = d_sync[1];
  assign fe     = c_prev & ~c_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one
// command frame on device clock edges, then check the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned REQ_CYCLES     = 200,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  ps2_state_t                state;
  logic [PS2_FRAME_BITS-1:0] frame;
  logic [3:0]                bit_cnt;
  logic [3:0]                next_bit;
  logic [31:0]               cnt;
  logic                      timeout_hit;
  logic                      ps2c_s;
  logic                      ps2d_s;
  logic                      fe;

  ps2_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .ps2c   (ps2c),
    .ps2d   (ps2d),
    .ps2c_s (ps2c_s),
    .ps2d_s (ps2d_s),
    .fe     (fe)
  );

  assign next_bit    = bit_cnt + 4'd1;
  assign timeout_hit = (cnt == TIMEOUT_CYCLES - 1);

  // Transmit sequencer; one counter serves the inhibit/request phases and the
  // inter-edge timeout. Line enables are registered so the pads never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      frame   <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
      ps2c_oe <= 1'b0;
      ps2d_oe <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          busy    <= 1'b0;
          if (start) begin
            frame   <= ps2_frame(din);
            cnt     <= '0;
            ps2c_oe <= 1'b1;
            busy    <= 1'b1;
            state   <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INHIBIT_CYCLES - 1) begin
            cnt     <= '0;
            ps2d_oe <= 1'b1;
            state   <= REQ;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        REQ: begin
          if (cnt == REQ_CYCLES - 1) begin
            cnt     <= '0;
            bit_cnt <= '0;
            ps2c_oe <= 1'b0;
            ps2d_oe <= ~frame[0];
            state   <= SEND;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        SEND: begin
          // Advance on the device falling edge so the new bit settles while
          // the device clock is low; the stop bit releases the data line.
          if (fe) begin
            cnt     <= '0;
            bit_cnt <= next_bit;
            ps2d_oe <= ~frame[next_bit];
            if (next_bit == 4'(PS2_STOP_IDX)) state <= ACK;
          end else if (timeout_hit) begin
            err     <= 1'b1;
            ps2d_oe <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ACK: begin
          if (fe) begin
            cnt <= '0;
            if (!ps2d_s) begin
              state <= WAIT_IDLE;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end else if (timeout_hit) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        WAIT_IDLE: begin
          if (ps2c_s && ps2d_s) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (fe) begin
            cnt <= '0;
          end else if (timeout_hit) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus, behavioural keyboard, and a
// cycle-by-cycle reference of the line enables derived from the frame rules.
module tb_ps2_host_tx;

  localparam int unsigned I_CYC = 20;
  localparam int unsigned R_CYC = 6;
  localparam int unsigned T_CYC = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] din = '0;
  logic       ps2c_oe, ps2d_oe, busy, done, err;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2c, ps2d;

  assign ps2c = ~(ps2c_oe | dev_clk_low);
  assign ps2d = ~(ps2d_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (I_CYC),
    .REQ_CYCLES     (R_CYC),
    .TIMEOUT_CYCLES (T_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .din     (din),
    .ps2c    (ps2c),
    .ps2d    (ps2d),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  // Reference state
  bit          mdl_active = 1'b0;
  int          acc_cyc = 0;
  logic [10:0] exp_bits = '0;
  int          fall_q[$];
  int          end_cyc = 0;
  logic        end_done = 1'b0;
  logic        end_err = 1'b0;
  logic [10:0] obs = '0;
  int          last_fall = 0;
  int          rel_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic bound_fail(input string name);
    checks++;
    $display("FAIL %s: wait bound expired, got no event expected one (cycle %0d)", name, cyc);
  endtask

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f = '0;
    f[10] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      if (b[i]) ones++;
    end
    f[9] = (ones % 2 == 0);
    return f;
  endfunction

  // Per-cycle comparison against the reference timeline of the transfer.
  initial begin
    int rel, nf, idx;
    logic ec, ed;
    forever begin
      @(posedge clk);
      #1;
      if (mdl_active) begin
        if (done || err) begin
          chk("end_lines", {29'd0, ps2c_oe, ps2d_oe, busy}, 32'd1);
          end_cyc = cyc; end_done = done; end_err = err;
          mdl_active = 1'b0;
        end else begin
          rel = cyc - acc_cyc;
          if (rel < int'(I_CYC)) begin
            ec = 1'b1; ed = 1'b0;
          end else if (rel < int'(I_CYC + R_CYC)) begin
            ec = 1'b1; ed = 1'b1;
          end else begin
            nf = 0;
            foreach (fall_q[j]) if (fall_q[j] + 3 <= cyc) nf++;
            idx = (nf > 10) ? 10 : nf;
            ec = 1'b0;
            ed = ~exp_bits[idx];
          end
          chk("lines", {29'd0, ps2c_oe, ps2d_oe, busy}, {29'd0, ec, ed, 1'b1});
        end
      end else if (cyc > end_cyc) begin
        chk("idle", {27'd0, ps2c_oe, ps2d_oe, busy, done, err}, 32'd0);
      end
    end
  end

  task automatic launch(input logic [7:0] b);
    @(negedge clk);
    exp_bits = exp_frame(b);
    fall_q.delete();
    obs = '0;
    start = 1'b1;
    din = b;
    acc_cyc = cyc + 1;
    mdl_active = 1'b1;
    @(negedge clk);
    start = 1'b0;
    din = $urandom;
  endtask

  // Keyboard: waits for the clock release, then clocks nf falling edges with
  // half-period h, sampling data on rising edges; optionally ACKs.
  task automatic device(input int nf, input int h, input bit ack);
    int guard;
    if (nf == 0) return;
    guard = 0;
    while (!ps2c_oe && guard < 1000) begin @(negedge clk); guard++; end
    while (ps2c_oe && guard < 1000) begin @(negedge clk); guard++; end
    if (guard >= 1000) begin
      bound_fail("dev_clock_release");
      return;
    end
    repeat (h) @(negedge clk);
    obs[0] = ps2d;
    for (int k = 1; k <= nf; k++) begin
      dev_clk_low = 1'b1;
      fall_q.push_back(cyc);
      last_fall = cyc;
      repeat (h) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) obs[k] = ps2d;
      if (k == 10 && ack) begin
        repeat (h / 2) @(negedge clk);
        dev_dat_low = 1'b1;
        repeat (h - h / 2) @(negedge clk);
      end else if (k == 11 && ack) begin
        repeat (2) @(negedge clk);
        dev_dat_low = 1'b0;
        rel_cyc = cyc;
      end else begin
        repeat (h) @(negedge clk);
      end
    end
  endtask

  task automatic wait_end();
    for (int i = 0; i < 3000 && mdl_active; i++) begin
      @(posedge clk);
      #2;
    end
    if (mdl_active) begin
      bound_fail("frame_end");
      mdl_active = 1'b0;
      end_cyc = cyc;
    end
  endtask

  task automatic ack_frame(input logic [7:0] b, input int h);
    launch(b);
    device(11, h, 1'b1);
    wait_end();
    chk("frame_bits", {21'd0, obs}, {21'd0, exp_bits});
    chk("done_pulse", {30'd0, end_done, end_err}, 32'd2);
    chk("done_cycle", end_cyc, rel_cyc + 3);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    int h;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", {27'd0, ps2c_oe, ps2d_oe, busy, done, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_outputs", {27'd0, ps2c_oe, ps2d_oe, busy, done, err}, 32'd0);

    // Reference frame pinned against hand-worked vectors
    chk("pin_ED", {21'd0, exp_frame(8'hED)}, {21'd0, 11'b111_1101_1010});
    chk("pin_07", {21'd0, exp_frame(8'h07)}, {21'd0, 11'b100_0000_1110});
    chk("pin_00", {21'd0, exp_frame(8'h00)}, {21'd0, 11'b110_0000_0000});

    // Set-LED command, then parity corner bytes
    ack_frame(8'hED, 15);
    chk("obs_ED_literal", {21'd0, obs}, {21'd0, 11'b111_1101_1010});
    ack_frame(8'h07, 12);
    chk("obs_07_parity", {31'd0, obs[9]}, 32'd0);
    ack_frame(8'h00, 10);
    chk("obs_00_parity", {31'd0, obs[9]}, 32'd1);
    ack_frame(8'hFF, 9);

    // Random bytes at random device clock rates
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      h = $urandom_range(8, 20);
      ack_frame(b, h);
    end

    // NACK: device leaves data high on the 11th falling edge
    launch(8'($urandom));
    device(11, 14, 1'b0);
    wait_end();
    chk("nack_err", {30'd0, end_done, end_err}, 32'd1);
    chk("nack_cycle", end_cyc, last_fall + 3);
    repeat (4) @(negedge clk);

    // Device never clocks: timeout counted from SEND entry
    launch(8'hED);
    wait_end();
    chk("tmo_err", {30'd0, end_done, end_err}, 32'd1);
    chk("tmo_cycle", end_cyc, acc_cyc + int'(I_CYC + R_CYC + T_CYC));
    repeat (4) @(negedge clk);

    // A start pulse mid-frame with another byte is ignored
    launch(8'hA5);
    fork
      device(11, 13, 1'b1);
      begin
        for (int i = 0; i < 2000 && fall_q.size() < 3; i++) @(negedge clk);
        start = 1'b1;
        din = 8'h3C;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_end();
    chk("ignore_start_bits", {21'd0, obs}, {21'd0, exp_frame(8'hA5)});
    chk("ignore_start_done", {30'd0, end_done, end_err}, 32'd2);
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-SEND while the data line is pulled low
    launch(8'hF0);
    device(4, 12, 1'b0);
    chk("pre_rst_data_pull", {31'd0, ps2d_oe}, 32'd1);
    mdl_active = 1'b0;
    end_cyc = cyc;
    rst = 1'b0;
    #1;
    chk("rst_async_release", {29'd0, ps2c_oe, ps2d_oe, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ack_frame(8'hED, 15);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
